mm_host_ctrl: RTL and testbench

Host-side sequencer for the shared BRAM of the matrix-multiply engine. It runs the other end of the engine's start/done and BRAM protocol. It accepts operand matrices A and B from an AXI-Stream-style input and writes them into the BRAM. It then pulses the engine's start, waits for done, and streams the N result words back out. It sits between the DMA/stream fabric and the multiplier, and drives the top-level BRAM port mux.

---
 rtl/mm_host_ctrl_if.sv | 49 ++++
 rtl/mm_host_ctrl.sv | 126 ++++++++++++
 tb/tb_mm_host_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mm_host_ctrl_if.sv
// Signal bundle between mm_host_ctrl (master) and its surroundings:
// operand stream in, result stream out, host BRAM port and engine start/done.
interface mm_host_ctrl_if #(
  parameter int L_RAM_SIZE = 3,
  parameter int BITWIDTH   = 32
);
  localparam int AW = 2 * L_RAM_SIZE + 1;

  logic [BITWIDTH-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic                s_tlast;

  logic [BITWIDTH-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;

  logic [AW-1:0]       bram_addr;
  logic [BITWIDTH-1:0] bram_wrdata;
  logic                bram_we;
  logic [BITWIDTH-1:0] bram_rddata;
  logic                bram_sel;

  logic                mm_start;
  logic                mm_done;

  modport master (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready,
    output bram_addr, bram_wrdata, bram_we, bram_sel,
    input  bram_rddata,
    output mm_start,
    input  mm_done
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready,
    input  bram_addr, bram_wrdata, bram_we, bram_sel,
    output bram_rddata,
    input  mm_start,
    output mm_done
  );
endinterface

// File: rtl/mm_host_ctrl.sv
// Host-side sequencer for the matrix-multiply BRAM: fills A and B from a stream,
// kicks the engine, waits for done, then drains C through a 2-entry output FIFO.
module mm_host_ctrl #(
  parameter int L_RAM_SIZE = 3,
  parameter int BITWIDTH   = 32
) (
  input  logic           clk,
  input  logic           reset,
  mm_host_ctrl_if.master bus,
  output logic           busy,
  output logic           err
);
  localparam int AW = 2 * L_RAM_SIZE + 1;
  localparam int N  = 1 << (2 * L_RAM_SIZE);
  localparam logic [AW-1:0] LAST_FILL = AW'(2 * N - 1);
  localparam logic [AW-1:0] RD_END    = AW'(N);

  typedef enum logic [2:0] {IDLE, FILL, START, WAIT, DRAIN} state_t;
  state_t state, next_state;

  logic [AW-1:0]       fill_cnt, rd_cnt;
  logic                done_seen, err_q, in_flight;
  logic [1:0]          occ;
  logic [BITWIDTH-1:0] head_data, tail_data;
  logic                head_last, tail_last;
  logic                fill_hs, pop, push, push_last, issue;

  assign fill_hs   = (state == FILL) && bus.s_tvalid;
  assign pop       = (occ != 2'd0) && bus.m_tready;
  assign push      = in_flight;
  // rd_cnt has already moved past the returning address, so N means word N-1
  assign push_last = (rd_cnt == RD_END);
  assign issue     = (state == DRAIN) && (rd_cnt != RD_END) &&
                     (({1'b0, occ} + {2'b00, in_flight} - {2'b00, pop}) < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.s_tvalid) next_state = FILL;
      FILL:    if (fill_hs && (fill_cnt == LAST_FILL)) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (done_seen && !bus.mm_done) next_state = DRAIN;
      DRAIN:   if (pop && head_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.s_tready    = (state == FILL);
    bus.bram_sel    = !((state == START) || (state == WAIT));
    bus.mm_start    = (state == START);
    bus.bram_we     = fill_hs;
    bus.bram_wrdata = fill_hs ? bus.s_tdata : '0;
    bus.bram_addr   = '0;
    if (fill_hs)    bus.bram_addr = fill_cnt;
    else if (issue) bus.bram_addr = rd_cnt;
    bus.m_tvalid    = (occ != 2'd0);
    bus.m_tdata     = (occ != 2'd0) ? head_data : '0;
    bus.m_tlast     = (occ != 2'd0) && head_last;
    busy            = (state != IDLE);
    err             = err_q;
  end

  // Counters, framing flag, done tracking and the output FIFO (head is the
  // entry presented on m_tdata, tail is only used when both slots are full).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt  <= '0;
      rd_cnt    <= '0;
      done_seen <= 1'b0;
      err_q     <= 1'b0;
      in_flight <= 1'b0;
      occ       <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
      head_last <= 1'b0;
      tail_last <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.s_tvalid) begin
        fill_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (fill_hs) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (bus.s_tlast != (fill_cnt == LAST_FILL)) err_q <= 1'b1;
      end
      if (state == START) done_seen <= 1'b0;
      if (state == WAIT) begin
        rd_cnt <= '0;
        if (bus.mm_done) done_seen <= 1'b1;
      end
      if (issue) rd_cnt <= rd_cnt + 1'b1;
      in_flight <= issue;

      if (push && pop) begin
        if (occ == 2'd1) begin
          head_data <= bus.bram_rddata;
          head_last <= push_last;
        end else begin
          head_data <= tail_data;
          head_last <= tail_last;
          tail_data <= bus.bram_rddata;
          tail_last <= push_last;
        end
      end else if (pop) begin
        head_data <= tail_data;
        head_last <= tail_last;
        occ       <= occ - 2'd1;
      end else if (push) begin
        if (occ == 2'd0) begin
          head_data <= bus.bram_rddata;
          head_last <= push_last;
        end else begin
          tail_data <= bus.bram_rddata;
          tail_last <= push_last;
        end
        occ <= occ + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mm_host_ctrl.sv
// Self-checking bench for mm_host_ctrl: BRAM + engine environment model, a table
// of whole-run scenarios compared against a plain matrix-product reference.
module tb_mm_host_ctrl;
  localparam int L = 3;
  localparam int W = 32;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  logic busy, err;
  always #5 clk = ~clk;

  mm_host_ctrl_if #(.L_RAM_SIZE(L), .BITWIDTH(W)) bus ();

  mm_host_ctrl #(.L_RAM_SIZE(L), .BITWIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  // Environment: BRAM with one-cycle read latency, and an engine that
  // overwrites A with A*B some cycles after start, then holds done.
  logic [W-1:0] mem [0:2*N-1];
  int eng_wait  = 0;
  int eng_hold  = 0;
  int done_hold = 3;

  always @(posedge clk) begin
    logic [W-1:0] acc;
    if (bus.bram_sel && bus.bram_we) mem[bus.bram_addr] <= bus.bram_wrdata;
    bus.bram_rddata <= mem[bus.bram_addr];
    if (bus.mm_start) eng_wait <= 3;
    else if (eng_wait > 0) begin
      if (eng_wait == 1) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) acc = acc + mem[i*8+k] * mem[N+k*8+j];
            mem[i*8+j] <= acc;
          end
        eng_hold <= done_hold;
      end
      eng_wait <= eng_wait - 1;
    end else if (eng_hold > 0) eng_hold <= eng_hold - 1;
  end
  assign bus.mm_done = (eng_hold > 0);

  typedef struct {
    bit ident;
    bit gap;
    int ready_mode;
    int last_pos;
    int hold;
    int abort_after;
    bit exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] stim [0:2*N-1];
  logic [W-1:0] expc [0:N-1];
  logic [W-1:0] got_q[$];
  int tlast_cnt, tlast_pos, start_cnt, last_hs_cyc, start_cyc;
  int sel_rise_cyc, done_fall_cyc, first_valid_cyc;
  int we_viol, sel_viol, stab_viol;
  bit completed;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_tready"}, bus.s_tready, 0);
    checkOutput({tag, "_m_tvalid"}, bus.m_tvalid, 0);
    checkOutput({tag, "_m_tdata"}, bus.m_tdata, 0);
    checkOutput({tag, "_m_tlast"}, bus.m_tlast, 0);
    checkOutput({tag, "_bram_we"}, bus.bram_we, 0);
    checkOutput({tag, "_bram_addr"}, bus.bram_addr, 0);
    checkOutput({tag, "_bram_wrdata"}, bus.bram_wrdata, 0);
    checkOutput({tag, "_bram_sel"}, bus.bram_sel, 1);
    checkOutput({tag, "_mm_start"}, bus.mm_start, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  // Operands plus the reference product, computed straight from the matrices.
  task automatic prepareData(input bit ident);
    for (int i = 0; i < N; i++) begin
      stim[i]   = ident ? W'((i / 8) == (i % 8)) : W'($urandom_range(0, 1000));
      stim[N+i] = ident ? W'(i) : W'($urandom_range(0, 1000));
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) s = s + stim[r*8+k] * stim[N+k*8+c];
        expc[r*8+c] = s;
      end
  endtask

  task automatic applyStimulus(input vec_t v);
    int fill_idx, cyc;
    bit hs, prev_stall, prev_last, prev_sel, prev_done;
    logic [W-1:0] prev_data;
    fill_idx = 0; cyc = 0;
    prev_stall = 0; prev_last = 0; prev_data = '0; prev_sel = 1; prev_done = 0;
    got_q.delete();
    tlast_cnt = 0; tlast_pos = -1; start_cnt = 0; last_hs_cyc = -10; start_cyc = -20;
    sel_rise_cyc = -1; done_fall_cyc = -10; first_valid_cyc = -1;
    we_viol = 0; sel_viol = 0; stab_viol = 0; completed = 0;
    done_hold = v.hold;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      if (fill_idx < 2*N && !(v.gap && (cyc % 3 == 2))) begin
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = stim[fill_idx];
        bus.s_tlast  = (fill_idx == v.last_pos);
      end else begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tlast  = 1'b0;
      end
      case (v.ready_mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.m_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      hs = bus.s_tvalid && bus.s_tready;
      if (bus.bram_we && !(hs && bus.bram_addr == 7'(fill_idx) && bus.bram_wrdata == bus.s_tdata))
        we_viol++;
      if (hs && !bus.bram_we) we_viol++;
      if (hs && fill_idx == 2*N-1) last_hs_cyc = cyc;
      if (hs) fill_idx++;
      if (bus.mm_start) begin start_cnt++; start_cyc = cyc; end
      if (bus.mm_done && bus.bram_sel) sel_viol++;
      if (prev_done && !bus.mm_done && done_fall_cyc < 0) done_fall_cyc = cyc;
      if (!prev_sel && bus.bram_sel && sel_rise_cyc < 0) sel_rise_cyc = cyc;
      if (bus.m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && !(bus.m_tvalid && bus.m_tdata == prev_data && bus.m_tlast == prev_last))
        stab_viol++;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_last  = bus.m_tlast;
      prev_sel   = bus.bram_sel;
      prev_done  = bus.mm_done;
      if (bus.m_tvalid && bus.m_tready) begin
        if (bus.m_tlast) begin tlast_cnt++; tlast_pos = got_q.size(); end
        got_q.push_back(bus.m_tdata);
      end
      cyc++;
      if (v.abort_after > 0 && got_q.size() == v.abort_after) begin completed = 1; break; end
      if (got_q.size() == N && !busy) begin completed = 1; break; end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = '0;
  endtask

  task automatic checkRun(input vec_t v);
    int bad;
    bad = 0;
    checkOutput("completed", completed, 1);
    checkOutput("out_count", got_q.size(), N);
    for (int i = 0; i < got_q.size() && i < N; i++)
      if (got_q[i] != expc[i]) begin
        if (bad == 0) $display("[TB] first bad word %0d: got %0d, expected %0d", i, got_q[i], expc[i]);
        bad++;
      end
    checkOutput("data_mismatches", bad, 0);
    checkOutput("tlast_count", tlast_cnt, 1);
    checkOutput("tlast_index", tlast_pos, N-1);
    checkOutput("err", err, v.exp_err);
    checkOutput("start_pulses", start_cnt, 1);
    checkOutput("start_after_last_fill", start_cyc, last_hs_cyc + 1);
    checkOutput("bram_write_violations", we_viol, 0);
    checkOutput("sel_while_done", sel_viol, 0);
    checkOutput("sel_rise_after_done_fall", sel_rise_cyc, done_fall_cyc + 1);
    checkOutput("first_valid_latency", first_valid_cyc - sel_rise_cyc, 2);
    checkOutput("stall_stability_violations", stab_viol, 0);
    checkOutput("busy_end", busy, 0);
  endtask

  initial begin
    vec_t vecs[8];
    bit prev_err;
    bit have_prev;
    // ident gap ready last hold abort exp_err
    vecs[0] = '{1, 0, 0, 2*N-1, 3, 0, 0};
    vecs[1] = '{1, 0, 1, 2*N-1, 3, 0, 0};
    vecs[2] = '{1, 1, 0, 2*N-1, 3, 0, 0};
    vecs[3] = '{1, 0, 0, 50,    3, 0, 1};
    vecs[4] = '{0, 0, 2, 2*N-1, 5, 0, 0};
    vecs[5] = '{0, 1, 2, 2*N-1, 4, 10, 0};
    vecs[6] = '{0, 0, 0, 2*N-1, 5, 0, 0};
    vecs[7] = '{0, 1, 2, 2*N-1, 1, 0, 0};

    reset = 1'b1;
    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tlast = 1'b0; bus.m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_sel", bus.bram_sel, 1);

    have_prev = 0;
    prev_err = 0;
    for (int r = 0; r < 8; r++) begin
      if (have_prev) checkOutput($sformatf("err_sticky_before_row%0d", r), err, prev_err);
      prepareData(vecs[r].ident);
      applyStimulus(vecs[r]);
      if (vecs[r].abort_after > 0) begin
        checkOutput("abort_reached", completed, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("mid_drain_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        have_prev = 0;
      end else begin
        checkRun(vecs[r]);
        prev_err  = vecs[r].exp_err;
        have_prev = 1;
      end
      repeat (2) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
